// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin sequencer for a bank of NREGS registers.
// One access at a time: IDLE -> SETUP -> COMMIT -> DONE, strobes held for SETUP and COMMIT.
module reg_bank_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             REQ,
  input  logic [1:0]             WE,
  input  logic [AW-1:0]          ADDR0,
  input  logic [AW-1:0]          ADDR1,
  input  logic [WIDTH-1:0]       WDATA0,
  input  logic [WIDTH-1:0]       WDATA1,
  input  logic [NREGS*WIDTH-1:0] Q_I,
  output logic [NREGS-1:0]       CS_O,
  output logic                   R_O,
  output logic                   W_O,
  output logic [WIDTH-1:0]       D_O,
  output logic [1:0]             ACK,
  output logic [WIDTH-1:0]       RDATA,
  output logic                   ERR,
  output logic                   BUSY
);

  typedef enum logic [1:0] {IDLE, SETUP, COMMIT, DONE} state_t;

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  state_t          state;
  logic            last_grant;
  logic            grant;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;

  logic            win;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [WIDTH-1:0] win_data;
  logic [NREGS-1:0] win_cs;
  logic            lat_valid;
  logic [WIDTH-1:0] rd_word;

  // Out-of-range addresses decode to no select at all.
  function automatic logic [NREGS-1:0] decode(input logic [AW-1:0] a);
    logic [NREGS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NREGS; k++)
      if ({1'b0, a} == (AW+1)'(k)) oh[k] = 1'b1;
    return oh;
  endfunction

  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can be inferred.
    rd_word = '0;
    // Contested requests alternate away from the last winner; a lone request always wins.
    win      = (REQ == 2'b11) ? ~last_grant : REQ[1];
    win_we   = WE[win];
    win_addr = win ? ADDR1  : ADDR0;
    win_data = win ? WDATA1 : WDATA0;
    win_cs   = decode(win_addr);
    lat_valid = ({1'b0, lat_addr} < NREGS_W);
    for (int k = 0; k < NREGS; k++)
      if ({1'b0, lat_addr} == (AW+1)'(k)) rd_word = Q_I[k*WIDTH +: WIDTH];
  end

  // NOTE: all state and registered outputs update with non-blocking assignments so every
  // register samples values from before the edge, regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      CS_O       <= '0;
      R_O        <= 1'b0;
      W_O        <= 1'b0;
      D_O        <= '0;
      ACK        <= 2'b00;
      RDATA      <= '0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ACK <= 2'b00;
          ERR <= 1'b0;
          if (|REQ) begin
            grant      <= win;
            last_grant <= win;
            lat_we     <= win_we;
            lat_addr   <= win_addr;
            CS_O       <= win_cs;
            D_O        <= win_data;
            W_O        <= win_we;
            R_O        <= ~win_we;
            BUSY       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          state <= COMMIT;
        end
        COMMIT: begin
          CS_O  <= '0;
          R_O   <= 1'b0;
          W_O   <= 1'b0;
          ACK   <= grant ? 2'b10 : 2'b01;
          ERR   <= ~lat_valid;
          // Writes leave RDATA alone; bad addresses return zero.
          if (!lat_valid)  RDATA <= '0;
          else if (!lat_we) RDATA <= rd_word;
          state <= DONE;
        end
        DONE: begin
          ACK   <= 2'b00;
          ERR   <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: a table of single accesses against a modelled
// register bank, plus hand sequences for reset abort, streaming contention and bad addresses.
module tb_reg_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req, we;
  logic [1:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [63:0] q;
  logic [3:0]  cs;
  logic        r, w;
  logic [15:0] d;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        err, busy;

  // Second instance with a 3-register bank so address 3 is out of range.
  logic [1:0]  e_req, e_we;
  logic [1:0]  e_addr0, e_addr1;
  logic [15:0] e_wdata0, e_wdata1;
  logic [47:0] e_q;
  logic [2:0]  e_cs;
  logic        e_r, e_w;
  logic [15:0] e_d;
  logic [1:0]  e_ack;
  logic [15:0] e_rdata;
  logic        e_err, e_busy;

  int n_pass  = 0;
  int n_total = 0;

  reg_bank_arbiter #(.WIDTH(16), .NREGS(4), .AW(2)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .WE(we), .ADDR0(addr0), .ADDR1(addr1),
    .WDATA0(wdata0), .WDATA1(wdata1), .Q_I(q), .CS_O(cs), .R_O(r), .W_O(w),
    .D_O(d), .ACK(ack), .RDATA(rdata), .ERR(err), .BUSY(busy)
  );

  reg_bank_arbiter #(.WIDTH(16), .NREGS(3), .AW(2)) dut3 (
    .CLK(clk), .RST(rst), .REQ(e_req), .WE(e_we), .ADDR0(e_addr0), .ADDR1(e_addr1),
    .WDATA0(e_wdata0), .WDATA1(e_wdata1), .Q_I(e_q), .CS_O(e_cs), .R_O(e_r), .W_O(e_w),
    .D_O(e_d), .ACK(e_ack), .RDATA(e_rdata), .ERR(e_err), .BUSY(e_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: writes on the clock edge while W and a chip select are high.
  logic [15:0] bank [4] = '{default: 16'h0000};
  always @(posedge clk)
    if (w)
      for (int k = 0; k < 4; k++)
        if (cs[k]) bank[k] <= d;
  assign q   = {bank[3], bank[2], bank[1], bank[0]};
  assign e_q = {16'h3333, 16'h2222, 16'h1111};

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  addr0;
    logic [1:0]  addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic [3:0]  cs;
    logic        w;
    logic [15:0] d;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Called at a falling edge; returns at the falling edge of the first idle cycle.
  task automatic run_txn(input vec_t v, input int idx);
    req = v.req; we = v.we; addr0 = v.addr0; addr1 = v.addr1;
    wdata0 = v.wdata0; wdata1 = v.wdata1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("v%0d cs c%0d", idx, c), 32'(cs), 32'(v.cs));
      check($sformatf("v%0d w c%0d", idx, c), 32'(w), 32'(v.w));
      check($sformatf("v%0d r c%0d", idx, c), 32'(r), 32'(!v.w));
      check($sformatf("v%0d d c%0d", idx, c), 32'(d), 32'(v.d));
      check($sformatf("v%0d ack-early c%0d", idx, c), 32'({ack, busy}), 32'({2'b00, 1'b1}));
      @(negedge clk);
    end
    check($sformatf("v%0d ack", idx), 32'(ack), 32'(v.ack));
    check($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
    check($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.rdata));
    check($sformatf("v%0d strobes-off", idx), 32'({cs, r, w}), 32'h0);
    req = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d ack-drop", idx), 32'(ack), 32'h0);
    check($sformatf("v%0d idle", idx), 32'(busy), 32'h0);
  endtask

  task automatic run_e(input logic [1:0] a, input logic [2:0] exp_cs,
                       input logic [15:0] exp_rd, input logic exp_err, input string tag);
    e_req = 2'b01; e_we = 2'b00; e_addr0 = a;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("%s cs c%0d", tag, c), 32'(e_cs), 32'(exp_cs));
      check($sformatf("%s r c%0d", tag, c), 32'(e_r), 32'h1);
    end
    @(negedge clk);
    check({tag, " ack"}, 32'(e_ack), 32'h1);
    check({tag, " err"}, 32'(e_err), 32'(exp_err));
    check({tag, " rdata"}, 32'(e_rdata), 32'(exp_rd));
    e_req = 2'b00;
    @(negedge clk);
    check({tag, " ack-drop"}, 32'({e_ack, e_err}), 32'h0);
  endtask

  initial begin
    //            req    we     a0    a1    wdata0    wdata1    cs       w     d         ack    rdata     err
    tbl[0]  = '{2'b11, 2'b00, 2'd1, 2'd2, 16'h0101, 16'h0202, 4'b0010, 1'b0, 16'h0101, 2'b01, 16'h0000, 1'b0};
    tbl[1]  = '{2'b01, 2'b01, 2'd2, 2'd0, 16'hA5C3, 16'h0000, 4'b0100, 1'b1, 16'hA5C3, 2'b01, 16'h0000, 1'b0};
    tbl[2]  = '{2'b10, 2'b00, 2'd0, 2'd2, 16'h0000, 16'h1111, 4'b0100, 1'b0, 16'h1111, 2'b10, 16'hA5C3, 1'b0};
    tbl[3]  = '{2'b01, 2'b01, 2'd0, 2'd0, 16'h1234, 16'h0000, 4'b0001, 1'b1, 16'h1234, 2'b01, 16'hA5C3, 1'b0};
    tbl[4]  = '{2'b10, 2'b10, 2'd0, 2'd1, 16'h0000, 16'h5A5A, 4'b0010, 1'b1, 16'h5A5A, 2'b10, 16'hA5C3, 1'b0};
    tbl[5]  = '{2'b10, 2'b00, 2'd0, 2'd1, 16'h0000, 16'h0000, 4'b0010, 1'b0, 16'h0000, 2'b10, 16'h5A5A, 1'b0};
    tbl[6]  = '{2'b11, 2'b00, 2'd0, 2'd3, 16'h7777, 16'h8888, 4'b0001, 1'b0, 16'h7777, 2'b01, 16'h1234, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 2'd0, 2'd3, 16'h7777, 16'h8888, 4'b1000, 1'b0, 16'h8888, 2'b10, 16'h0000, 1'b0};
    tbl[8]  = '{2'b11, 2'b11, 2'd3, 2'd0, 16'hBEEF, 16'hCAFE, 4'b1000, 1'b1, 16'hBEEF, 2'b01, 16'h0000, 1'b0};
    tbl[9]  = '{2'b10, 2'b00, 2'd0, 2'd3, 16'h0000, 16'h0000, 4'b1000, 1'b0, 16'h0000, 2'b10, 16'hBEEF, 1'b0};
    // Read after an aborted write: reset clears RDATA, then reg 2 still holds A5C3.
    tbl[10] = '{2'b10, 2'b00, 2'd0, 2'd2, 16'h0000, 16'h0000, 4'b0100, 1'b0, 16'h0000, 2'b10, 16'hA5C3, 1'b0};

    rst = 1'b1;
    req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    e_req = 2'b00; e_we = 2'b00; e_addr0 = '0; e_addr1 = '0;
    e_wdata0 = 16'h0000; e_wdata1 = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset strobes", 32'({cs, r, w, d}), 32'h0);
    check("reset ack/err/busy", 32'({ack, err, busy}), 32'h0);
    check("reset rdata", 32'(rdata), 32'h0);
    rst = 1'b0;

    // Contested request latched, then a mid-cycle reset aborts it.
    req = 2'b11; we = 2'b00; addr0 = 2'd1; addr1 = 2'd2;
    @(posedge clk);
    @(negedge clk);
    check("pre-abort busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("abort strobes", 32'({cs, r, w}), 32'h0);
    check("abort ack/busy", 32'({ack, err, busy}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(tbl[i], i);

    // REQ=11 held: grants alternate 0,1,0,1 with one ACK every 4 cycles.
    req = 2'b11; we = 2'b00; addr0 = 2'd0; addr1 = 2'd1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check($sformatf("stream ack cyc%0d", i), 32'(ack),
            (i % 4 == 3) ? (((i / 4) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      if (i == 15) req = 2'b00;
    end
    @(negedge clk);
    check("stream idle", 32'(busy), 32'h0);

    // Reset during COMMIT of a write: strobes drop at once and no ACK follows.
    req = 2'b01; we = 2'b01; addr0 = 2'd3; wdata0 = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("commit write strobe", 32'({cs, w}), 32'({4'b1000, 1'b1}));
    #2 rst = 1'b1;
    #1;
    check("commit abort strobes", 32'({cs, r, w}), 32'h0);
    check("commit abort ack/busy", 32'({ack, busy}), 32'h0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    run_txn(tbl[10], 10);

    // Three-register bank: address 3 is invalid.
    run_e(2'd3, 3'b000, 16'h0000, 1'b1, "bad-addr");
    run_e(2'd2, 3'b100, 16'h3333, 1'b0, "good-addr");
    run_e(2'd3, 3'b000, 16'h0000, 1'b1, "bad-again");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
